// File: rtl/pwm_slew.sv
// Slew-rate limiter feeding a dual-channel center-aligned PWM: steps the applied
// magnitude toward the host target once per PWM period, with a host-silence watchdog.
module pwm_slew #(
  parameter int unsigned STEP = 4,
  parameter int unsigned TMO  = 8388608
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgt_we_a,
  input  logic       tgt_we_b,
  input  logic [7:0] tgt_a,
  input  logic [7:0] tgt_b,
  input  logic       trig,
  output logic       we_a,
  output logic       we_b,
  output logic [7:0] mag_a,
  output logic [7:0] mag_b,
  output logic [7:0] rdt_a,
  output logic [7:0] rdt_b,
  output logic       busy,
  output logic       tmo
);

  typedef enum logic {
    WAIT  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [23:0] WD_LAST = 24'(TMO - 1);
  localparam logic [8:0]  STEP9   = 9'(STEP);

  state_t      state, state_nxt;
  logic [7:0]  tgt_a_q, tgt_b_q;
  logic [7:0]  cur_a_q, cur_b_q;
  logic        trig_q;
  logic [23:0] wd_cnt;
  logic        tmo_q;

  logic fall;
  logic host_we;
  logic wd_fire;
  logic do_step;

  assign fall    = trig_q & ~trig;
  assign host_we = tgt_we_a | tgt_we_b;
  // The timeout fires once; while tmo is set the saturated counter must not re-arm it.
  assign wd_fire = ~tmo_q & ~host_we & (wd_cnt == WD_LAST);
  assign do_step = (state == WAIT) & fall;

  // One bounded step toward the target; the 9-bit difference cannot wrap.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] diff;
    diff = '0;
    slew = cur;
    if (STEP == 0) begin
      slew = tgt;
    end else if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      slew = (diff > STEP9) ? 8'(cur + STEP9[7:0]) : tgt;
    end else if (tgt < cur) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      slew = (diff > STEP9) ? 8'(cur - STEP9[7:0]) : tgt;
    end
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    if (wd_fire || fall) state_nxt = ISSUE;
      ISSUE:   state_nxt = wd_fire ? ISSUE : WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_a_q <= '0;
      tgt_b_q <= '0;
      cur_a_q <= '0;
      cur_b_q <= '0;
      trig_q  <= 1'b0;
      wd_cnt  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      trig_q <= trig;

      if (host_we) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_LAST) begin
        wd_cnt <= wd_cnt + 24'd1;
      end

      if (host_we) begin
        tmo_q <= 1'b0;
      end else if (wd_fire) begin
        tmo_q <= 1'b1;
      end

      if (wd_fire) begin
        tgt_a_q <= '0;
        tgt_b_q <= '0;
        cur_a_q <= '0;
        cur_b_q <= '0;
      end else begin
        // The step reads the pre-edge target, so a colliding host write lands next period.
        if (tgt_we_a) tgt_a_q <= tgt_a;
        if (tgt_we_b) tgt_b_q <= tgt_b;
        if (do_step) begin
          cur_a_q <= slew(cur_a_q, tgt_a_q);
          cur_b_q <= slew(cur_b_q, tgt_b_q);
        end
      end
    end
  end

  assign we_a  = (state == ISSUE);
  assign we_b  = (state == ISSUE);
  assign mag_a = cur_a_q;
  assign mag_b = cur_b_q;
  assign rdt_a = tgt_a_q;
  assign rdt_b = tgt_b_q;
  assign busy  = (cur_a_q != tgt_a_q) | (cur_b_q != tgt_b_q);
  assign tmo   = tmo_q;

endmodule

// File: tb/tb_pwm_slew.sv
// Bench for pwm_slew: two instances (STEP=4 and STEP=0) against a per-cycle
// arithmetic reference model, with scenario tasks and randomized traffic.
module tb_pwm_slew;

  localparam int TMO = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic trig  = 1'b0;

  logic [1:0]      t_we_a = '0;
  logic [1:0]      t_we_b = '0;
  logic [1:0][7:0] t_a    = '0;
  logic [1:0][7:0] t_b    = '0;

  wire [1:0]      o_we_a, o_we_b, o_busy, o_tmo;
  wire [1:0][7:0] o_mag_a, o_mag_b, o_rdt_a, o_rdt_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index [instance] or [instance][channel].
  int m_tgt [2][2];
  int m_cur [2][2];
  bit m_iss [2];
  int m_idle[2];
  bit m_tmo [2];
  bit m_trq;

  always #5 clk = ~clk;

  pwm_slew #(.STEP(4), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tgt_we_a(t_we_a[0]), .tgt_we_b(t_we_b[0]), .tgt_a(t_a[0]), .tgt_b(t_b[0]),
    .trig(trig),
    .we_a(o_we_a[0]), .we_b(o_we_b[0]), .mag_a(o_mag_a[0]), .mag_b(o_mag_b[0]),
    .rdt_a(o_rdt_a[0]), .rdt_b(o_rdt_b[0]), .busy(o_busy[0]), .tmo(o_tmo[0])
  );

  pwm_slew #(.STEP(0), .TMO(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .tgt_we_a(t_we_a[1]), .tgt_we_b(t_we_b[1]), .tgt_a(t_a[1]), .tgt_b(t_b[1]),
    .trig(trig),
    .we_a(o_we_a[1]), .we_b(o_we_b[1]), .mag_a(o_mag_a[1]), .mag_b(o_mag_b[1]),
    .rdt_a(o_rdt_a[1]), .rdt_b(o_rdt_b[1]), .busy(o_busy[1]), .tmo(o_tmo[1])
  );

  function automatic int step_of(int k);
    return (k == 0) ? 4 : 0;
  endfunction

  // Move toward the target by at most st; st == 0 jumps straight there.
  function automatic int slew_ref(int cur, int tgt, int st);
    int d;
    if (st == 0) return tgt;
    d = tgt - cur;
    if (d > st)  d = st;
    if (d < -st) d = -st;
    return cur + d;
  endfunction

  function automatic logic [35:0] exp_vec(int k);
    logic busy_e;
    busy_e = (m_cur[k][0] != m_tgt[k][0]) || (m_cur[k][1] != m_tgt[k][1]);
    return {m_iss[k], m_iss[k], 8'(m_cur[k][0]), 8'(m_cur[k][1]),
            8'(m_tgt[k][0]), 8'(m_tgt[k][1]), busy_e, m_tmo[k]};
  endfunction

  function automatic logic [35:0] dut_vec(int k);
    return {o_we_a[k], o_we_b[k], o_mag_a[k], o_mag_b[k],
            o_rdt_a[k], o_rdt_b[k], o_busy[k], o_tmo[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        m_tgt[k][c] = 0;
        m_cur[k][c] = 0;
      end
      m_iss[k]  = 1'b0;
      m_idle[k] = 0;
      m_tmo[k]  = 1'b0;
    end
    m_trq = 1'b0;
  endtask

  // Advance one clock; inputs are sampled by the model at the edge, outputs
  // are safe to read on return (1 time unit after the edge).
  task automatic cycle();
    bit fall, any, to;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      fall = m_trq && !trig;
      for (int k = 0; k < 2; k++) begin
        any = t_we_a[k] || t_we_b[k];
        to  = !m_tmo[k] && !any && (m_idle[k] == TMO - 1);
        if (to) begin
          for (int c = 0; c < 2; c++) begin
            m_tgt[k][c] = 0;
            m_cur[k][c] = 0;
          end
          m_iss[k] = 1'b1;
          m_tmo[k] = 1'b1;
        end else begin
          if (fall && !m_iss[k]) begin
            for (int c = 0; c < 2; c++)
              m_cur[k][c] = slew_ref(m_cur[k][c], m_tgt[k][c], step_of(k));
            m_iss[k] = 1'b1;
          end else begin
            m_iss[k] = 1'b0;
          end
          if (t_we_a[k]) m_tgt[k][0] = int'(t_a[k]);
          if (t_we_b[k]) m_tgt[k][1] = int'(t_b[k]);
          if (any) begin
            m_idle[k] = 0;
            m_tmo[k]  = 1'b0;
          end else if (m_idle[k] < TMO - 1) begin
            m_idle[k]++;
          end
        end
      end
      m_trq = trig;
    end
    #1;
  endtask

  task automatic host_write(int k, int ch, int v);
    if (ch == 0) begin t_we_a[k] = 1'b1; t_a[k] = 8'(v); end
    else         begin t_we_b[k] = 1'b1; t_b[k] = 8'(v); end
    cycle();
    t_we_a[k] = 1'b0;
    t_we_b[k] = 1'b0;
  endtask

  // One PWM period of random length; counts write pulses seen on one channel.
  task automatic period_count(int k, int ch, output int pulses, output int last_mag);
    int hi, lo;
    logic w;
    hi = $urandom_range(5, 12);
    lo = $urandom_range(5, 12);
    pulses   = 0;
    last_mag = -1;
    trig = 1'b1;
    repeat (hi) cycle();
    trig = 1'b0;
    for (int i = 0; i < lo; i++) begin
      cycle();
      w = (ch == 0) ? o_we_a[k] : o_we_b[k];
      if (w) begin
        pulses++;
        last_mag = (ch == 0) ? int'(o_mag_a[k]) : int'(o_mag_b[k]);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dut_vec(k) !== 36'h0) $display("FAIL reset_held[%0d]: got %h expected 0", k, dut_vec(k));
      else n_pass++;
    end
    rst_n = 1'b1;
    repeat (4) cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dut_vec(k) !== exp_vec(k)) $display("FAIL reset_idle[%0d]: got %h expected %h", k, dut_vec(k), exp_vec(k));
      else n_pass++;
    end
  endtask

  task automatic test_ramp_up();
    int p, m;
    host_write(0, 0, 200);
    for (int i = 1; i <= 50; i++) begin
      period_count(0, 0, p, m);
      n_checks++;
      if (p !== 1 || m !== m_cur[0][0] || m !== 4 * i)
        $display("FAIL ramp_up period %0d: pulses %0d mag %0d, expected 1 pulse mag %0d", i, p, m, 4 * i);
      else n_pass++;
    end
    n_checks++;
    if (o_busy[0] !== 1'b0 || o_mag_a[0] !== 8'd200)
      $display("FAIL ramp_up_end: busy %0b mag %0d, expected busy 0 mag 200", o_busy[0], o_mag_a[0]);
    else n_pass++;
  endtask

  task automatic test_ramp_down();
    int p, m, periods, prev;
    host_write(0, 0, 2);
    periods = 0;
    prev    = 200;
    while (m_cur[0][0] != 2 && periods < 60) begin
      period_count(0, 0, p, m);
      periods++;
      n_checks++;
      if (p !== 1 || m !== m_cur[0][0] || m < 2 || prev - m > 4)
        $display("FAIL ramp_down period %0d: pulses %0d mag %0d, expected 1 pulse mag %0d", periods, p, m, m_cur[0][0]);
      else n_pass++;
      prev = m;
    end
    n_checks++;
    if (periods !== 50 || o_busy[0] !== 1'b0 || o_mag_a[0] !== 8'd2)
      $display("FAIL ramp_down_end: periods %0d busy %0b mag %0d, expected 50 0 2", periods, o_busy[0], o_mag_a[0]);
    else n_pass++;
  endtask

  task automatic test_collide();
    int p, m;
    host_write(0, 0, 0);
    period_count(0, 0, p, m);
    trig = 1'b1;
    repeat (6) cycle();
    trig      = 1'b0;
    t_we_a[0] = 1'b1;
    t_a[0]    = 8'd100;
    cycle();
    t_we_a[0] = 1'b0;
    n_checks++;
    if (o_we_a[0] !== 1'b1 || o_mag_a[0] !== 8'd0 || o_rdt_a[0] !== 8'd100)
      $display("FAIL collide_first: we %0b mag %0d rdt %0d, expected 1 0 100", o_we_a[0], o_mag_a[0], o_rdt_a[0]);
    else n_pass++;
    repeat (6) cycle();
    period_count(0, 0, p, m);
    n_checks++;
    if (p !== 1 || m !== 4) $display("FAIL collide_next: pulses %0d mag %0d, expected 1 4", p, m);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int p, m, n, guard;
    bit seen;
    t_we_a[0] = 1'b1; t_a[0] = 8'd60;
    t_we_b[0] = 1'b1; t_b[0] = 8'd60;
    cycle();
    t_we_a[0] = 1'b0;
    t_we_b[0] = 1'b0;
    guard = 0;
    while ((m_cur[0][0] != 60 || m_cur[0][1] != 60) && guard < 40) begin
      period_count(0, 0, p, m);
      guard++;
    end
    n_checks++;
    if (o_mag_a[0] !== 8'd60 || o_mag_b[0] !== 8'd60)
      $display("FAIL tmo_ramp: mag %0d/%0d, expected 60/60", o_mag_a[0], o_mag_b[0]);
    else n_pass++;
    // Refresh, then stay silent; the firing edge also sees a fall.
    host_write(0, 0, 60);
    n    = 0;
    seen = 1'b0;
    trig = 1'b1;
    while (!seen && n < 2 * TMO) begin
      trig = (n >= TMO - 1) ? 1'b0 : 1'b1;
      cycle();
      n++;
      seen = o_tmo[0];
    end
    n_checks++;
    if (!seen || n !== TMO || o_we_a[0] !== 1'b1 || o_we_b[0] !== 1'b1 ||
        o_mag_a[0] !== 8'd0 || o_mag_b[0] !== 8'd0)
      $display("FAIL tmo_fire: seen %0b after %0d cycles we %0b%0b mag %0d/%0d, expected 1 after %0d, we 11, mag 0/0",
               seen, n, o_we_a[0], o_we_b[0], o_mag_a[0], o_mag_b[0], TMO);
    else n_pass++;
    repeat (4) cycle();
    period_count(0, 1, p, m);
    n_checks++;
    if (p !== 1 || m !== 0 || o_tmo[0] !== 1'b1)
      $display("FAIL tmo_keepalive: pulses %0d mag %0d tmo %0b, expected 1 0 1", p, m, o_tmo[0]);
    else n_pass++;
    host_write(0, 0, 60);
    n_checks++;
    if (o_tmo[0] !== 1'b0 || o_rdt_a[0] !== 8'd60)
      $display("FAIL tmo_clear: tmo %0b rdt %0d, expected 0 60", o_tmo[0], o_rdt_a[0]);
    else n_pass++;
  endtask

  task automatic test_wd_collide();
    host_write(0, 0, 10);
    trig = 1'b1;
    repeat (TMO - 1) cycle();
    host_write(0, 1, 33);
    repeat (5) cycle();
    n_checks++;
    if (o_tmo[0] !== 1'b0 || o_rdt_b[0] !== 8'd33 || o_rdt_a[0] !== 8'd10)
      $display("FAIL wd_collide: tmo %0b rdt %0d/%0d, expected 0 10/33", o_tmo[0], o_rdt_a[0], o_rdt_b[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p, m, pulses;
    host_write(0, 0, 200);
    repeat (3) period_count(0, 0, p, m);
    trig = 1'b1;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dut_vec(k) !== 36'h0) $display("FAIL reset_mid_ramp[%0d]: got %h expected 0", k, dut_vec(k));
      else n_pass++;
    end
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      trig = ((i / 4) % 2 == 0);
      cycle();
      if (o_we_a != 2'b00 || o_we_b != 2'b00) pulses++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL reset_no_we: pulses %0d expected 0", pulses);
    else n_pass++;
    rst_n = 1'b1;
    host_write(0, 0, 200);
    trig = 1'b1;
    repeat (6) cycle();
    trig = 1'b0;
    cycle();
    n_checks++;
    if (o_we_a[0] !== 1'b1 || o_mag_a[0] !== 8'd4)
      $display("FAIL reset_issue_pre: we %0b mag %0d, expected 1 4", o_we_a[0], o_mag_a[0]);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec(0) !== 36'h0) $display("FAIL reset_in_issue: got %h expected 0", dut_vec(0));
    else n_pass++;
    repeat (4) cycle();
    rst_n = 1'b1;
    period_count(0, 0, p, m);
    n_checks++;
    if (p !== 1 || m !== 0) $display("FAIL reset_first_fall: pulses %0d mag %0d, expected 1 0", p, m);
    else n_pass++;
  endtask

  task automatic test_bypass();
    int p, m;
    host_write(1, 1, 255);
    period_count(1, 1, p, m);
    n_checks++;
    if (p !== 1 || m !== 255) $display("FAIL bypass_first: pulses %0d mag %0d, expected 1 255", p, m);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      period_count(1, 1, p, m);
      n_checks++;
      if (p !== 1 || m !== 255 || o_busy[1] !== 1'b0)
        $display("FAIL bypass_keepalive %0d: pulses %0d mag %0d busy %0b, expected 1 255 0", i, p, m, o_busy[1]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int half_left;
    half_left = $urandom_range(5, 12);
    trig = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (half_left == 0) begin
        trig      = ~trig;
        half_left = $urandom_range(5, 12);
      end
      half_left--;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 19) == 0) begin t_we_a[k] = 1'b1; t_a[k] = 8'($urandom); end
        if ($urandom_range(0, 19) == 0) begin t_we_b[k] = 1'b1; t_b[k] = 8'($urandom); end
      end
      cycle();
      t_we_a = '0;
      t_we_b = '0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dut_vec(k) !== exp_vec(k))
          $display("FAIL random[%0d] cycle %0d: got %h expected %h", k, i, dut_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_collide();
    test_timeout();
    test_wd_collide();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
